stdcore_spram_arb: RTL and testbench

Two-requester arbiter/sequencer in front of one `stdcore_spram` instance: it grants one request per cycle, drives the RAM's `ce_n`/`we_n`/`addr`/`wdata`, and routes read data back to the requester that issued the read. The block sits between the prediction/transform pipeline clients and a shared single-port buffer, so two stages can share one macro without stalling logic of their own.

---
 rtl/stdcore_spram_arb.sv | 100 ++++++++++
 tb/tb_stdcore_spram_arb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stdcore_spram_arb.sv
// Two-port arbiter in front of one stdcore_spram; define SPRAM_ARB_RR_EN
// for round-robin arbitration when free (default: port 0 has priority).
module stdcore_spram_arb #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic          p0_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_rvalid,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_ce_n,
  output logic          ram_we_n,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] rd_pend_q, rd_pend_d;
  logic       g0, g1;
  logic       free_pick1;

`ifdef SPRAM_ARB_RR_EN
  logic rr_q, rr_d;

  assign free_pick1 = p1_valid & (~p0_valid | rr_q);
  assign rr_d = (state_q == FREE && (g0 || g1)) ? ~rr_q : rr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`else
  assign free_pick1 = p1_valid & ~p0_valid;
`endif

  // Grants are gated by rst_n so nothing issues while reset is held.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        (state_q == OWN0): g0 = p0_valid;
        (state_q == OWN1): g1 = p1_valid;
        default: begin
          g1 = free_pick1;
          g0 = p0_valid & ~free_pick1;
        end
      endcase
    end
  end

  assign p0_ready = g0;
  assign p1_ready = g1;

  assign ram_ce_n  = ~(g0 | g1);
  assign ram_we_n  = g1 ? ~p1_we : (g0 ? ~p0_we : 1'b1);
  assign ram_addr  = g1 ? p1_addr : p0_addr;
  assign ram_wdata = g1 ? p1_wdata : p0_wdata;

  always_comb begin
    state_d = state_q;
    if (g0)      state_d = p0_lock ? OWN0 : FREE;
    else if (g1) state_d = p1_lock ? OWN1 : FREE;
  end

  assign rd_pend_d = {g1 & ~p1_we, g0 & ~p0_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FREE;
      rd_pend_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign p0_rvalid = rd_pend_q[0];
  assign p1_rvalid = rd_pend_q[1];
  assign rdata     = ram_rdata;

endmodule

// File: tb/tb_stdcore_spram_arb.sv
// Directed bench for stdcore_spram_arb with a behavioural single-port RAM.
module tb_stdcore_spram_arb;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic p0_valid = 0, p0_we = 0, p0_lock = 0;
  logic p1_valid = 0, p1_we = 0, p1_lock = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic ram_ce_n, ram_we_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad = 0;
  int gexp, gprev;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!ram_ce_n) begin
      if (!ram_we_n) mem[ram_addr] <= ram_wdata;
      else           ram_rdata <= mem[ram_addr];
    end

  stdcore_spram_arb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we),
    .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rvalid(p0_rvalid),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we),
    .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rvalid(p1_rvalid),
    .rdata(rdata), .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held with a write request pending
    p0_valid = 1; p0_we = 1; p0_addr = 10'h010; p0_wdata = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_ce_n", ram_ce_n, 1);
      chk("rst_p0_ready", p0_ready, 0);
      chk("rst_p0_rvalid", p0_rvalid, 0);
      cyc();
    end
    rst_n = 1;
    // write then read, port 0
    p0_wdata = 32'hA5A5_0001;
    #1;
    chk("rel_p0_ready", p0_ready, 1);
    chk("wr_ce_n", ram_ce_n, 0);
    chk("wr_we_n", ram_we_n, 0);
    cyc();
    p0_we = 0;
    #1;
    chk("rd_p0_ready", p0_ready, 1);
    chk("rd_we_n", ram_we_n, 1);
    chk("rd_p1_rvalid0", p1_rvalid, 0);
    cyc();
    p0_valid = 0;
    chk("rd_p0_rvalid", p0_rvalid, 1);
    chk("rd_rdata", rdata, 32'hA5A5_0001);
    chk("rd_p1_rvalid1", p1_rvalid, 0);
    cyc();
    chk("rd_p0_rvalid_off", p0_rvalid, 0);
    chk("idle_ce_n", ram_ce_n, 1);

    // contention: both ports reading continuously
    p0_valid = 1; p0_we = 0; p0_addr = 10'h010;
    p1_valid = 1; p1_we = 0; p1_addr = 10'h020;
    gprev = -1;
    for (int i = 0; i < 8; i++) begin
`ifdef SPRAM_ARB_RR_EN
      gexp = i % 2;
`else
      gexp = 0;
`endif
      #1;
      chk("ct_p0_ready", p0_ready, gexp == 0);
      chk("ct_p1_ready", p1_ready, gexp == 1);
      chk("ct_p0_rvalid", p0_rvalid, gprev == 0);
      chk("ct_p1_rvalid", p1_rvalid, gprev == 1);
      gprev = gexp;
      cyc();
    end
    p0_valid = 0; p1_valid = 0;
    #1;
    chk("ct_last_p0_rvalid", p0_rvalid, gprev == 0);
    chk("ct_last_p1_rvalid", p1_rvalid, gprev == 1);
    cyc();

    // lock: port 1 acquires with a write, holds, idles, then releases
    p1_valid = 1; p1_we = 1; p1_lock = 1;
    p1_addr = 10'h020; p1_wdata = 32'h0000_1234;
    #1;
    chk("lk_acq_p1_ready", p1_ready, 1);
    cyc();
    p0_valid = 1; p0_we = 0; p0_lock = 0; p0_addr = 10'h010;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lk_beat_p0_ready", p0_ready, 0);
      chk("lk_beat_p1_ready", p1_ready, 1);
      cyc();
    end
    p1_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lk_idle_p0_ready", p0_ready, 0);
      chk("lk_idle_ce_n", ram_ce_n, 1);
      cyc();
    end
    p1_valid = 1; p1_we = 0; p1_lock = 0;
    #1;
    chk("lk_last_p0_ready", p0_ready, 0);
    chk("lk_last_p1_ready", p1_ready, 1);
    cyc();
    p1_valid = 0;
    #1;
    chk("lk_rel_p0_ready", p0_ready, 1);
    chk("lk_p1_rvalid", p1_rvalid, 1);
    chk("lk_p1_rdata", rdata, 32'h0000_1234);
    cyc();
    p0_valid = 0;
    chk("lk_p0_rvalid", p0_rvalid, 1);
    chk("lk_p0_rdata", rdata, 32'hA5A5_0001);
    cyc();

    // reset mid-read; port 0 takes the lock so release is observable
    p0_valid = 1; p0_we = 0; p0_lock = 1;
    #1;
    chk("mr_p0_ready", p0_ready, 1);
    cyc();
    rst_n = 0;
    p0_we = 1; p0_lock = 0; p0_wdata = 32'hDEAD_BEEF;
    #1;
    chk("mr_p0_rvalid", p0_rvalid, 0);
    chk("mr_ce_n", ram_ce_n, 1);
    cyc();
    cyc();
    rst_n = 1; p0_valid = 0;
    #1;
    chk("mr_rel_ce_n", ram_ce_n, 1);
    chk("mr_rel_rvalid", p0_rvalid, 0);
    cyc();
    chk("mr_idle_ce_n", ram_ce_n, 1);
    p1_valid = 1; p1_we = 0; p1_lock = 0; p1_addr = 10'h010;
    #1;
    chk("mr_free_p1_ready", p1_ready, 1);
    cyc();
    p1_valid = 0;
    chk("mr_nowrite_rdata", rdata, 32'hA5A5_0001);
    chk("mr_p1_rvalid", p1_rvalid, 1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
